// File: rtl/apb_pkg.sv
// Shared types for the MVU APB master.
//   apb_state_t : APB master FSM states.
//   apb_req_t   : one queued APB request {write, addr, wdata}.
//   APB_REQ_W   : width in bits of apb_req_t, used to size the request FIFO.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } apb_req_t;

    localparam int APB_REQ_W = $bits(apb_req_t);

endpackage

// File: rtl/mvu_apb_req_fifo.sv
// Synchronous request FIFO with extra-bit pointers.
//   clk, rst        : clock and synchronous active-high reset
//   push, wdata     : write side; a push is ignored when full, even if a pop
//                     happens in the same cycle
//   pop             : read side; a pop is ignored when empty
//   rdata           : head entry
//   rdata_next      : entry behind the head, so the master can start the next
//                     transfer in the same cycle it retires the current one
//   full, empty     : status
//   count           : number of stored entries
module mvu_apb_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [WIDTH-1:0]         rdata_next,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [IW-1:0]    rd_idx_next;
    logic             do_push;
    logic             do_pop;

    // Same index with different wrap bits means the write side lapped the read side.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    assign count       = wr_ptr - rd_ptr;
    assign do_push     = push && !full;
    assign do_pop      = pop && !empty;
    assign rd_idx_next = rd_ptr[IW-1:0] + IW'(1);
    assign rdata       = mem[rd_ptr[IW-1:0]];
    assign rdata_next  = mem[rd_idx_next];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr[IW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mvu_apb_master.sv
// APB master for the MVU register slave: queues requests, runs them one at a
// time as SETUP/ACCESS pairs, returns read data, and latches MVU interrupts.
//   clk, rst                              : clock, synchronous active-high reset
//   req_valid/ready, req_write/addr/wdata : request queue input
//   rsp_valid/ready, rsp_rdata            : read response (held until taken)
//   paddr, psel, penable, pwrite, pwdata  : registered APB outputs
//   prdata                                : APB read data
//   mvu_irq, irq_clr, irq_pend, irq       : interrupt edge latch and clear
//   busy                                  : any transfer, queued request or response outstanding
//
// state     | meaning
// ST_IDLE   | bus quiet; waits for a queued request and no held response
// ST_SETUP  | psel=1, penable=0, address/direction/data from the FIFO head
// ST_ACCESS | psel=1, penable=1 for ACCESS_WAIT+1 cycles; last cycle retires
module mvu_apb_master #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACCESS_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic [7:0]  mvu_irq,
    input  logic [7:0]  irq_clr,
    output logic [7:0]  irq_pend,
    output logic        irq,
    output logic        busy
);

    import apb_pkg::*;

    localparam int CNT_W = (ACCESS_WAIT > 0) ? $clog2(ACCESS_WAIT + 1) : 1;
    localparam int PW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(ACCESS_WAIT);

    apb_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    apb_req_t         push_req;
    apb_req_t         head;
    apb_req_t         head_next;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [PW-1:0]    fifo_count;
    logic             last_access;
    logic [7:0]       irq_prev;

    // req_ready is forced low while reset is asserted so nothing is accepted into a FIFO being cleared.
    assign req_ready   = !fifo_full && !rst;
    assign fifo_push   = req_valid && req_ready;
    assign push_req    = '{write: req_write, addr: req_addr, wdata: req_wdata};
    assign last_access = (state == ST_ACCESS) && (wait_cnt == '0);
    assign fifo_pop    = last_access;

    mvu_apb_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (APB_REQ_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .wdata      (push_req),
        .pop        (fifo_pop),
        .rdata      (head),
        .rdata_next (head_next),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A held response blocks new transfers to keep reads strictly ordered.
                    if (!fifo_empty && !rsp_valid) begin
                        state  <= ST_SETUP;
                        psel   <= 1'b1;
                        paddr  <= head.addr;
                        pwrite <= head.write;
                        pwdata <= head.wdata;
                    end
                end
                ST_SETUP: begin
                    state    <= ST_ACCESS;
                    penable  <= 1'b1;
                    wait_cnt <= WAIT_LOAD;
                end
                ST_ACCESS: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end else begin
                        penable <= 1'b0;
                        if (!pwrite) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= prdata;
                        end
                        // More than one entry now means another is left after this pop.
                        if (pwrite && (fifo_count > PW'(1))) begin
                            state  <= ST_SETUP;
                            paddr  <= head_next.addr;
                            pwrite <= head_next.write;
                            pwdata <= head_next.wdata;
                        end else begin
                            state <= ST_IDLE;
                            psel  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
            endcase
        end
    end

    // Set has priority over clear so an edge arriving with a clear is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev <= '0;
            irq_pend <= '0;
        end else begin
            irq_prev <= mvu_irq;
            irq_pend <= (irq_pend & ~irq_clr) | (mvu_irq & ~irq_prev);
        end
    end

    assign irq  = |irq_pend;
    assign busy = (state != ST_IDLE) || !fifo_empty || rsp_valid;

endmodule

// File: tb/tb_mvu_apb_master.sv
// Bench for mvu_apb_master: two instances (ACCESS_WAIT 0 and 2) share all
// inputs; each has its own transaction-level reference model checked every cycle,
// plus directed checks against instance 0.
module tb_mvu_apb_master;
    import apb_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    logic [31:0] prdata;
    logic [7:0]  mvu_irq;
    logic [7:0]  irq_clr;

    wire [1:0]       req_ready_o;
    wire [1:0]       rsp_valid_o;
    wire [1:0]       psel_o;
    wire [1:0]       penable_o;
    wire [1:0]       pwrite_o;
    wire [1:0]       irq_o;
    wire [1:0]       busy_o;
    wire [1:0][31:0] rsp_rdata_o;
    wire [1:0][31:0] paddr_o;
    wire [1:0][31:0] pwdata_o;
    wire [1:0][7:0]  irq_pend_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic string tg(input int i, input string s);
        return $sformatf("d%0d_%s", i, s);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int GI    = g;
        localparam int WAITS = (g == 0) ? 0 : 2;

        mvu_apb_master #(
            .FIFO_DEPTH  (DEPTH),
            .ACCESS_WAIT (WAITS)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid),
            .req_ready (req_ready_o[g]),
            .req_write (req_write),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .rsp_valid (rsp_valid_o[g]),
            .rsp_ready (rsp_ready),
            .rsp_rdata (rsp_rdata_o[g]),
            .paddr     (paddr_o[g]),
            .psel      (psel_o[g]),
            .penable   (penable_o[g]),
            .pwrite    (pwrite_o[g]),
            .pwdata    (pwdata_o[g]),
            .prdata    (prdata),
            .mvu_irq   (mvu_irq),
            .irq_clr   (irq_clr),
            .irq_pend  (irq_pend_o[g]),
            .irq       (irq_o[g]),
            .busy      (busy_o[g])
        );

        // Reference model: queue of accepted requests, bus phase (0 idle,
        // 1 setup, 2 access), remaining access cycles, held response, last bus values.
        apb_req_t    q[$];
        int          phase     = 0;
        int          left      = 0;
        logic        rv        = 1'b0;
        logic [31:0] rd        = '0;
        logic [31:0] la        = '0;
        logic        lw        = 1'b0;
        logic [31:0] ld        = '0;
        logic [7:0]  pend      = '0;
        logic [7:0]  prev      = '0;
        int          en_run    = 0;
        int          psel_cnt  = 0;
        int          burst_cnt = 0;
        logic        psel_prev = 1'b0;

        always @(negedge clk) begin
            logic rv_old;
            logic start;
            logic was_read;
            int   sz;
            apb_req_t nreq;

            chk_val(tg(GI, "psel"),      64'(psel_o[GI]),      64'(phase != 0));
            chk_val(tg(GI, "penable"),   64'(penable_o[GI]),   64'(phase == 2));
            chk_val(tg(GI, "paddr"),     64'(paddr_o[GI]),     64'(la));
            chk_val(tg(GI, "pwrite"),    64'(pwrite_o[GI]),    64'(lw));
            chk_val(tg(GI, "pwdata"),    64'(pwdata_o[GI]),    64'(ld));
            chk_val(tg(GI, "rsp_valid"), 64'(rsp_valid_o[GI]), 64'(rv));
            chk_val(tg(GI, "rsp_rdata"), 64'(rsp_rdata_o[GI]), 64'(rd));
            chk_val(tg(GI, "busy"),      64'(busy_o[GI]),      64'((phase != 0) || (q.size() > 0) || rv));
            chk_val(tg(GI, "req_ready"), 64'(req_ready_o[GI]), 64'(!rst && (q.size() < DEPTH)));
            chk_val(tg(GI, "irq_pend"),  64'(irq_pend_o[GI]),  64'(pend));
            chk_val(tg(GI, "irq"),       64'(irq_o[GI]),       64'(pend != 8'h00));

            if (penable_o[GI]) begin
                en_run++;
            end else if (en_run != 0) begin
                chk_val(tg(GI, "en_len"), 64'(en_run), 64'(WAITS + 1));
                en_run = 0;
            end
            if (psel_o[GI]) begin
                psel_cnt++;
                if (!psel_prev) burst_cnt++;
            end
            psel_prev = psel_o[GI];

            if (rst) begin
                q.delete();
                phase  = 0;
                left   = 0;
                rv     = 1'b0;
                rd     = '0;
                la     = '0;
                lw     = 1'b0;
                ld     = '0;
                pend   = '0;
                prev   = '0;
                en_run = 0;
            end else begin
                pend   = (pend & ~irq_clr) | (mvu_irq & ~prev);
                prev   = mvu_irq;
                sz     = q.size();
                rv_old = rv;
                start  = 1'b0;
                if (rv && rsp_ready) rv = 1'b0;
                if (phase == 0) begin
                    if (sz > 0 && !rv_old) start = 1'b1;
                end else if (phase == 1) begin
                    phase = 2;
                    left  = WAITS;
                end else if (left > 0) begin
                    left--;
                end else begin
                    was_read = !q[0].write;
                    if (was_read) begin
                        rv = 1'b1;
                        rd = prdata;
                    end
                    void'(q.pop_front());
                    if (q.size() > 0 && !was_read) start = 1'b1;
                    else phase = 0;
                end
                if (start) begin
                    phase = 1;
                    la    = q[0].addr;
                    lw    = q[0].write;
                    ld    = q[0].wdata;
                end
                if (req_valid && sz < DEPTH) begin
                    nreq.write = req_write;
                    nreq.addr  = req_addr;
                    nreq.wdata = req_wdata;
                    q.push_back(nreq);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int  ps0;
        int  bc0;
        logic ok;
        int  guard;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = 32'h1234_5678;
        mvu_irq   = '0;
        irq_clr   = '0;

        repeat (3) tick();
        chk_val("rst_req_ready", 64'(req_ready_o[0]), 64'd0);
        chk_val("rst_busy",      64'(busy_o[0]),      64'd0);
        chk_val("rst_psel",      64'(psel_o[0]),      64'd0);
        rst = 1'b0;
        tick();
        chk_val("post_rst_ready", 64'(req_ready_o[0]), 64'd1);

        // single write, latency from the accepting edge
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0120; req_wdata = 32'hDEAD_BEEF;
        tick();
        req_valid = 1'b0;
        chk_val("wr_n_psel", 64'(psel_o[0]), 64'd0);
        tick();
        chk_val("wr_n1_psel",   64'(psel_o[0]),    64'd1);
        chk_val("wr_n1_pen",    64'(penable_o[0]), 64'd0);
        chk_val("wr_n1_paddr",  64'(paddr_o[0]),   64'h120);
        chk_val("wr_n1_pwrite", 64'(pwrite_o[0]),  64'd1);
        tick();
        chk_val("wr_n2_pen",    64'(penable_o[0]), 64'd1);
        chk_val("wr_n2_pwdata", 64'(pwdata_o[0]),  64'hDEAD_BEEF);
        tick();
        chk_val("wr_n3_psel",  64'(psel_o[0]),      64'd0);
        chk_val("wr_n3_rsp",   64'(rsp_valid_o[0]), 64'd0);
        chk_val("wr_n3_paddr", 64'(paddr_o[0]),     64'h120);
        repeat (6) tick();

        // read held by rsp_ready=0 with a write queued behind it
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_wdata = '0;
        tick();
        req_write = 1'b1; req_addr = 32'h80; req_wdata = 32'h55;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk_val("rd_rsp_valid", 64'(rsp_valid_o[0]), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_val("rd_hold_valid", 64'(rsp_valid_o[0]), 64'd1);
            chk_val("rd_hold_data",  64'(rsp_rdata_o[0]), 64'h1234_5678);
            chk_val("rd_hold_psel",  64'(psel_o[0]),      64'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk_val("rd_clr_valid", 64'(rsp_valid_o[0]), 64'd0);
        chk_val("rd_clr_psel",  64'(psel_o[0]),      64'd0);
        tick();
        chk_val("wq_psel",  64'(psel_o[0]),  64'd1);
        chk_val("wq_paddr", 64'(paddr_o[0]), 64'h80);
        repeat (8) tick();

        // five writes into a four-deep FIFO behind a held read response
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h44;
        tick();
        req_valid = 1'b0;
        repeat (8) tick();
        ps0 = gen_dut[0].psel_cnt;
        bc0 = gen_dut[0].burst_cnt;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_write = 1'b1;
            req_addr  = 32'h200 + 32'(i * 4);
            req_wdata = $urandom;
            if (i == 4) rsp_ready = 1'b1;
            ok = 1'b0;
            guard = 0;
            while (!ok && guard < 50) begin
                ok = req_ready_o[0];
                tick();
                guard++;
            end
            chk_val("push_accept", 64'(ok), 64'd1);
            if (i == 3) chk_val("ready_full", 64'(req_ready_o[0]), 64'd0);
        end
        req_valid = 1'b0;
        repeat (30) tick();
        chk_val("b2b_psel_cycles", 64'(gen_dut[0].psel_cnt - ps0), 64'd10);
        chk_val("b2b_bursts",      64'(gen_dut[0].burst_cnt - bc0), 64'd1);

        // interrupt edge arriving together with its clear
        mvu_irq = 8'h08; irq_clr = 8'h08;
        tick();
        irq_clr = 8'h00;
        chk_val("irq_set_pend", 64'(irq_pend_o[0][3]), 64'd1);
        chk_val("irq_set_irq",  64'(irq_o[0]),         64'd1);
        irq_clr = 8'h08;
        tick();
        irq_clr = 8'h00;
        chk_val("irq_clr_pend", 64'(irq_pend_o[0]), 64'd0);
        chk_val("irq_clr_irq",  64'(irq_o[0]),      64'd0);
        mvu_irq = 8'h00;
        repeat (2) tick();

        // reset in the middle of an ACCESS with two requests still queued
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_write = 1'b1;
            req_addr  = 32'h300 + 32'(i * 4);
            req_wdata = $urandom;
            tick();
        end
        req_valid = 1'b0;
        chk_val("abort_in_access", 64'(penable_o[0]), 64'd1);
        rst = 1'b1;
        tick();
        chk_val("abort_psel", 64'(psel_o[0]), 64'd0);
        rst = 1'b0;
        tick();
        chk_val("abort_psel_after", 64'(psel_o[0]),      64'd0);
        chk_val("abort_busy",       64'(busy_o[0]),      64'd0);
        chk_val("abort_ready",      64'(req_ready_o[0]), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_val("abort_quiet", 64'(psel_o[0]), 64'd0);
        end

        // randomized traffic, checked by the per-instance models
        for (int c = 0; c < 1500; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            req_valid = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
            req_addr  = $urandom;
            req_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 9) < 6);
            prdata    = $urandom;
            mvu_irq   = mvu_irq ^ 8'($urandom & $urandom);
            irq_clr   = 8'($urandom & $urandom & $urandom);
            tick();
        end

        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1; irq_clr = '0;
        repeat (40) tick();
        chk_val("drain_busy0", 64'(busy_o[0]), 64'd0);
        chk_val("drain_busy1", 64'(busy_o[1]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mvu_apb_master.md
MVU_APB_MASTER -- requirements
Module: mvu_apb_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4 (power of two, ≥2): request FIFO entries.
REQ-002 SHALL have parameter ACCESS_WAIT, default 0: extra ACCESS-phase cycles per transfer.
REQ-003 SHALL have one clock and a synchronous active-high reset:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have these request ports:
- req_valid  in  1  request offered.
- req_ready  out  1  FIFO can accept.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address, passed unmodified to paddr.
- req_wdata  in  32  write data.
REQ-005 SHALL have these response ports:
- rsp_valid  out  1  read data held.
- rsp_ready  in  1  consumer takes read data.
- rsp_rdata  out  32  read data.
REQ-006 SHALL have these APB ports:
- paddr  out  32  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  32  APB write data.
- prdata  in  32  APB read data from the MVU APB slave.
REQ-007 SHALL have these interrupt and status ports:
- mvu_irq  in  8  per-MVU interrupt level.
- irq_clr  in  8  per-bit pending clear.
- irq_pend  out  8  latched pending interrupts.
- irq  out  1  OR of irq_pend.
- busy  out  1  work outstanding.

Function
REQ-008 SHALL assert req_ready = !fifo_full and push on req_valid && req_ready; a push is refused when full even if a pop occurs in the same cycle.
REQ-009 SHALL run an FSM with states IDLE, SETUP and ACCESS, with all APB outputs registered.
REQ-010 IDLE SHALL go to SETUP when the FIFO is non-empty and rsp_valid = 0; otherwise it SHALL stay in IDLE.
REQ-011 SETUP SHALL drive psel = 1 and penable = 0, with paddr, pwrite and pwdata taken from the FIFO head, and SHALL go to ACCESS the next cycle.
REQ-012 ACCESS SHALL drive psel = 1 and penable = 1 for ACCESS_WAIT+1 cycles, counted by a wait counter, holding paddr, pwrite and pwdata stable.
REQ-013 On the last ACCESS cycle the block SHALL pop the FIFO, and for a read it SHALL capture prdata into rsp_rdata and set rsp_valid.
REQ-014 After the last ACCESS cycle the FSM SHALL go directly to SETUP (back-to-back) when the FIFO still has an entry and no read was just completed; otherwise it SHALL go to IDLE.
REQ-015 Latency with ACCESS_WAIT = 0, request accepted at edge N into an empty FIFO in IDLE:
- psel high after edge N+1.
- penable high after edge N+2.
- rsp_valid high after edge N+3.
REQ-016 rsp_valid SHALL hold, with rsp_rdata stable, until rsp_valid && rsp_ready, then clear at the next edge; no transfer starts while rsp_valid = 1 (strict ordering).
REQ-017 Write transfers SHALL produce no response.
REQ-018 Outside SETUP and ACCESS, psel = 0 and penable = 0; paddr, pwrite and pwdata SHALL hold their last values.
REQ-019 irq_pend[i] SHALL set on a rising edge of mvu_irq[i], detected against a registered previous value, and clear on irq_clr[i]; set wins when both occur in the same cycle.
REQ-020 irq SHALL equal |irq_pend.
REQ-021 busy SHALL equal (state != IDLE) || FIFO non-empty || rsp_valid.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with full and empty distinguished by an extra pointer bit.

Reset
REQ-023 While rst is high at a clock edge, the block SHALL:
- set the FSM to IDLE and empty the FIFO;
- clear the wait counter;
- set psel, penable, pwrite, rsp_valid, irq_pend, irq and busy to 0;
- set paddr, pwdata and rsp_rdata to 0, and set the previous-irq register to 0;
- set req_ready to 0 during reset and to 1 after it.
REQ-024 A reset during SETUP or ACCESS SHALL abort the transfer (psel = 0 after the reset edge) and discard all queued requests and any pending response.

Structure
REQ-025 The FSM state enum and the request struct {write, addr, wdata} SHALL live in the shared apb_pkg.
REQ-026 The request FIFO SHALL be one sub-module, mvu_apb_req_fifo, a synchronous FIFO parameterised by depth and width using the same clk/rst.

Verification
REQ-027 Single write with addr 0x0000_0120 and wdata 0xDEAD_BEEF:
- psel after edge 1 and penable after edge 2, with paddr = 0x120 and pwrite = 1.
- no rsp_valid.
REQ-028 Read of addr 0x40 with prdata = 0x1234_5678 and rsp_ready = 0 for 5 cycles:
- rsp_valid held with rsp_rdata = 0x1234_5678.
- a queued write does not start until the cycle after rsp_ready = 1.
REQ-029 Push 5 writes back-to-back with FIFO_DEPTH = 4:
- req_ready drops after the 4th push.
- all 5 writes appear on APB in order as SETUP/ACCESS pairs, with no IDLE cycle between writes.
REQ-030 ACCESS_WAIT = 2: penable stays high for exactly 3 cycles per transfer, and prdata is sampled only on the 3rd cycle.
REQ-031 mvu_irq[3] pulses 0→1 while irq_clr[3] = 1 in the same cycle: irq_pend[3] = 1 and irq = 1; a later irq_clr[3] = 1 gives irq_pend = 0.
REQ-032 Assert rst during ACCESS with 2 requests queued: psel = 0, busy = 0 and req_ready = 1 one cycle after rst deasserts, and no further APB activity follows.
